// File: rtl/banked_mem_resp.sv
// Four-bank interleaved word memory responder with fixed bank occupancy and a fixed-latency read pipeline.
// Optional macro BANK_CONFLICT_ERR_EN: a request to a busy bank also raises err.
module banked_mem_resp #(
    parameter int ADDR_W   = 16,
    parameter int RD_LAT   = 2,
    parameter int BANK_OCC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       data_in,
    input  logic              rd,
    input  logic              wr,
    input  logic              createdump,
    output logic [15:0]       data_out,
    output logic              stall,
    output logic [3:0]        busy,
    output logic              err
);
    localparam int WORD_W = ADDR_W - 1;
    localparam int DEPTH  = 1 << WORD_W;
    localparam int CNT_W  = $clog2(BANK_OCC + 1);

    logic [1:0]        bank;
    logic [WORD_W-1:0] word;
    logic              req;
    logic              accept;
    logic              acc_rd;
    logic              acc_wr;

    logic [CNT_W-1:0] occ_q [4];
    logic [CNT_W-1:0] occ_d [4];
    logic [15:0]      pipe_q [RD_LAT];
    logic [15:0]      pipe_d [RD_LAT];
    logic [15:0]      mem_q [DEPTH];

    // Handshake: rd/wr is the request-valid, held by the initiator; the
    // responder is ready when stall and err are both low, and the access
    // transfers on the rising edge where valid and ready coincide.
    assign bank   = addr[2:1];
    assign word   = addr[ADDR_W-1:1];
    assign req    = rd | wr;
    assign stall  = req & busy[bank];
    assign accept = (rd ^ wr) & ~addr[0] & ~busy[bank] & ~rst;
    assign acc_rd = accept & rd;
    assign acc_wr = accept & wr;

    always_comb begin
        err = (rd & wr) | (req & addr[0]);
`ifdef BANK_CONFLICT_ERR_EN
        err = err | stall;
`endif
    end

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            busy[b]  = (occ_q[b] != '0);
            occ_d[b] = occ_q[b];
            if (accept && bank == 2'(b)) begin
                occ_d[b] = CNT_W'(BANK_OCC);
            end else if (occ_q[b] != '0) begin
                occ_d[b] = occ_q[b] - CNT_W'(1);
            end
        end
    end

    // Idle pipeline stages carry zero so data_out needs no separate valid gate.
    always_comb begin
        pipe_d[0] = acc_rd ? mem_q[word] : 16'h0000;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    assign data_out = pipe_q[RD_LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 4; b++) begin
                occ_q[b] <= '0;
            end
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                occ_q[b] <= occ_d[b];
            end
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (acc_wr) begin
            mem_q[word] <= data_in;
        end
    end

`ifndef SYNTHESIS
    task automatic dump_array();
        for (int i = 0; i < DEPTH; i++) begin
            if (mem_q[i] != 16'h0000) begin
                $display("%h %h", {i[WORD_W-1:0], 1'b0}, mem_q[i]);
            end
        end
    endtask

    always @(posedge clk) begin
        if (createdump) dump_array();
    end
`endif

endmodule

// File: tb/tb_banked_mem_resp.sv
// Bench for banked_mem_resp: directed test-plan steps then random traffic, checked against a
// cycle-numbered reference model (bank free times, word array, due-cycle read queue).
module tb_banked_mem_resp;
    localparam int RD_LAT   = 2;
    localparam int BANK_OCC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        rd;
    logic        wr;
    logic        createdump;
    logic [15:0] data_out;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    banked_mem_resp #(.ADDR_W(16), .RD_LAT(RD_LAT), .BANK_OCC(BANK_OCC)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .data_in    (data_in),
        .rd         (rd),
        .wr         (wr),
        .createdump (createdump),
        .data_out   (data_out),
        .stall      (stall),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          busy_until [4];
    logic [15:0] mem_m [int];
    logic [15:0] exp_q [$];
    int          exp_cyc_q [$];

    logic [15:0] last_dout;
    logic [3:0]  last_busy;
    logic        last_stall;
    logic        last_err;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive, compare every output mid-cycle, then advance the model past the edge.
    task automatic cycle(input logic r, input logic w, input logic [15:0] a,
                         input logic [15:0] d, input logic rs, output logic acc);
        logic [3:0]  eb;
        logic [1:0]  bk;
        logic        es;
        logic        ee;
        logic [15:0] ed;
        rst = rs; rd = r; wr = w; addr = a; data_in = d;
        @(negedge clk);
        for (int b = 0; b < 4; b++) eb[b] = (cyc <= busy_until[b]);
        bk = a[2:1];
        es = (r | w) & eb[bk];
        ee = (r & w) | ((r | w) & a[0]);
`ifdef BANK_CONFLICT_ERR_EN
        ee = ee | es;
`endif
        ed = 16'h0000;
        if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
            ed = exp_q.pop_front();
            void'(exp_cyc_q.pop_front());
        end
        check("busy", 16'(busy), 16'(eb));
        check("stall", 16'(stall), 16'(es));
        check("err", 16'(err), 16'(ee));
        check("data_out", data_out, ed);
        last_dout = data_out; last_busy = busy; last_stall = stall; last_err = err;
        acc = (r ^ w) & ~a[0] & ~eb[bk] & ~rs;
        if (rs) begin
            for (int b = 0; b < 4; b++) if (busy_until[b] > cyc) busy_until[b] = cyc;
            exp_q.delete();
            exp_cyc_q.delete();
        end else if (acc) begin
            busy_until[bk] = cyc + BANK_OCC;
            if (w) begin
                mem_m[int'(a[15:1])] = d;
            end else begin
                exp_q.push_back(mem_m[int'(a[15:1])]);
                exp_cyc_q.push_back(cyc + RD_LAT);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, acc);
    endtask

    task automatic hold_req(input logic r, input logic w, input logic [15:0] a,
                            input logic [15:0] d, output int stalls);
        logic acc;
        stalls = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(r, w, a, d, 1'b0, acc);
            if (last_stall) stalls++;
            if (acc) break;
        end
    endtask

    logic        acc;
    int          stalls;
    logic [15:0] douts [8];
    logic [15:0] ra;
    logic        rr;
    logic        rw;
    logic        rrs;
    int          kind;

    initial begin
        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = 16'h0000; data_in = 16'h0000; createdump = 1'b0;
        for (int b = 0; b < 4; b++) busy_until[b] = -1;
        repeat (3) @(posedge clk);
        #1;
        cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, acc);
        check("reset_busy", 16'(last_busy), 16'h0000);
        check("reset_dout", last_dout, 16'h0000);

        // Preload words 0..15 in bank rotation, plus word 0x0030.
        for (int i = 0; i < 16; i++) hold_req(1'b0, 1'b1, 16'(i * 2), 16'($urandom_range(1, 65535)), stalls);
        idle(4);
        hold_req(1'b0, 1'b1, 16'h0030, 16'h1234, stalls);
        idle(4);

        // Write then read.
        cycle(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, acc);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check("wr_busy0_held", 16'(last_busy[0]), 16'h0001);
        end
        cycle(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, acc);
        check("rd_after_wr_no_stall", 16'(last_stall), 16'h0000);
        idle(1);
        check("rd_lat_early", last_dout, 16'h0000);
        idle(1);
        check("rd_lat_data", last_dout, 16'hBEEF);
        idle(1);
        check("rd_lat_late", last_dout, 16'h0000);
        idle(4);

        // Bank pipelining.
        for (int i = 0; i < 4; i++) hold_req(1'b0, 1'b1, 16'(i * 2), 16'((i + 1) * 16'h1111), stalls);
        idle(4);
        for (int i = 0; i < 8; i++) begin
            if (i < 4) cycle(1'b1, 1'b0, 16'(i * 2), 16'h0000, 1'b0, acc);
            else idle(1);
            douts[i] = last_dout;
            if (i < 4) check("pipe_no_stall", 16'(last_stall), 16'h0000);
        end
        for (int i = 0; i < 4; i++) check("pipe_data", douts[i + 2], 16'((i + 1) * 16'h1111));
        idle(4);

        // Bank conflict, request held until accepted.
        cycle(1'b0, 1'b1, 16'h0008, 16'hA5A5, 1'b0, acc);
        cycle(1'b1, 1'b0, 16'h0018, 16'h0000, 1'b0, acc);
`ifdef BANK_CONFLICT_ERR_EN
        check("conflict_err", 16'(last_err), 16'h0001);
`else
        check("conflict_err", 16'(last_err), 16'h0000);
`endif
        hold_req(1'b1, 1'b0, 16'h0018, 16'h0000, stalls);
        check("conflict_stalls", 16'(stalls), 16'h0003);
        idle(4);

        // Protocol errors.
        cycle(1'b1, 1'b1, 16'h0020, 16'h7777, 1'b0, acc);
        check("rdwr_err", 16'(last_err), 16'h0001);
        idle(1);
        check("rdwr_busy", 16'(last_busy), 16'h0000);
        cycle(1'b1, 1'b0, 16'h0021, 16'h0000, 1'b0, acc);
        check("odd_err", 16'(last_err), 16'h0001);
        idle(4);

        // Reset mid-read; array keeps its contents.
        cycle(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, acc);
        cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, acc);
        idle(1);
        check("rst_dout", last_dout, 16'h0000);
        check("rst_busy", 16'(last_busy), 16'h0000);
        cycle(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, acc);
        idle(2);
        check("rst_keeps_array", last_dout, 16'hBEEF);
        idle(4);

        // A write during reset does not commit.
        cycle(1'b0, 1'b1, 16'h0030, 16'h5555, 1'b1, acc);
        cycle(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0, acc);
        idle(2);
        check("rst_write_dropped", last_dout, 16'h1234);
        idle(4);

        // Random traffic over the preloaded words.
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 9);
            ra = 16'($urandom_range(0, 15)) << 1;
            if ($urandom_range(0, 15) == 0) ra[0] = 1'b1;
            rr = (kind <= 3) || (kind == 7);
            rw = (kind >= 4) && (kind <= 7);
            rrs = ($urandom_range(0, 63) == 0);
            cycle(rr, rw, ra, 16'($urandom), rrs, acc);
        end
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
